// File: rtl/psram_burst_ctrl_if.sv
// Bus bundle between a burst master (FML side) and the PSRAM burst controller,
// including the PSRAM pin-level signals the controller drives and samples.
interface psram_burst_ctrl_if #(
    parameter int ADDR_W = 23
);
    logic              ready;
    logic [ADDR_W-1:0] fml_adr;
    logic              fml_stb;
    logic              fml_we;
    logic [3:0]        fml_sel;
    logic [31:0]       fml_di;
    logic [31:0]       fml_do;
    logic              fml_ack;
    logic              err;
    logic              mem_clk_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_dq_i;
    logic [15:0]       mem_dq_o;
    logic              mem_dq_oe;
    logic [1:0]        mem_be_n;
    logic              mem_we_n;
    logic              mem_oe_n;
    logic              mem_ce_n;
    logic              mem_adv_n;
    logic              mem_cre;
    logic              mem_wait;

    modport slave (
        output ready, fml_do, fml_ack, err,
        output mem_clk_en, mem_addr, mem_dq_o, mem_dq_oe, mem_be_n,
        output mem_we_n, mem_oe_n, mem_ce_n, mem_adv_n, mem_cre,
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        input  mem_dq_i, mem_wait
    );

    modport master (
        input  ready, fml_do, fml_ack, err,
        input  mem_clk_en, mem_addr, mem_dq_o, mem_dq_oe, mem_be_n,
        input  mem_we_n, mem_oe_n, mem_ce_n, mem_adv_n, mem_cre,
        output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        output mem_dq_i, mem_wait
    );
endinterface

// File: rtl/psram_burst_ctrl.sv
// Synchronous-burst PSRAM controller: power-up wait, BCR programming, then
// 32-bit FML bursts split into pairs of 16-bit memory words with wait timeout.
module psram_burst_ctrl #(
    parameter int                ADDR_W       = 23,
    parameter int                BURST        = 4,
    parameter int                STARTUP_CYC  = 15000,
    parameter logic [ADDR_W-1:0] BCR_VAL      = ADDR_W'(23'h10_1D1F),
    parameter int                BCR_WE_CYC   = 6,
    parameter int                WAIT_TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    psram_burst_ctrl_if.slave bus
);
    localparam int CNT_MAX = (STARTUP_CYC > BCR_WE_CYC) ? STARTUP_CYC : BCR_WE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WIDX_W  = $clog2(2 * BURST);
    localparam int TO_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WIDX_W-1:0] W_LAST = WIDX_W'(2 * BURST - 1);

    typedef enum logic [3:0] {
        ST_STARTUP, ST_BCR_ADV, ST_BCR_HOLD, ST_BCR_WE, ST_IDLE,
        ST_RD_ADDR, ST_RD_XFER, ST_WR_ADDR, ST_WR_XFER, ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDX_W-1:0] w_q, w_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wsel_q, wsel_d;
    logic [15:0]       hold_q, hold_d;
    logic [31:0]       do_q, do_d;
    logic              rd_ack_q, rd_ack_d;
    logic              ready_q, ready_d;

    logic              wr_ack;
    logic              err_pulse;
    logic              clk_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       dq_o;
    logic              dq_oe;
    logic [1:0]        be_n;
    logic              we_n, oe_n, ce_n, adv_n, cre;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STARTUP;
            cnt_q    <= '0;
            w_q      <= '0;
            to_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wsel_q   <= '0;
            hold_q   <= '0;
            do_q     <= '0;
            rd_ack_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            to_q     <= to_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wsel_q   <= wsel_d;
            hold_q   <= hold_d;
            do_q     <= do_d;
            rd_ack_q <= rd_ack_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        to_d      = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wsel_d    = wsel_q;
        hold_d    = hold_q;
        do_d      = do_q;
        rd_ack_d  = 1'b0;
        ready_d   = ready_q;
        wr_ack    = 1'b0;
        err_pulse = 1'b0;
        clk_en    = 1'b0;
        mem_addr  = '0;
        dq_o      = '0;
        dq_oe     = 1'b0;
        be_n      = 2'b11;
        we_n      = 1'b1;
        oe_n      = 1'b1;
        ce_n      = 1'b1;
        adv_n     = 1'b1;
        cre       = 1'b0;

        unique case (state_q)
            ST_STARTUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STARTUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_BCR_ADV;
                end
            end
            ST_BCR_ADV: begin
                ce_n     = 1'b0;
                adv_n    = 1'b0;
                cre      = 1'b1;
                mem_addr = BCR_VAL;
                state_d  = ST_BCR_HOLD;
            end
            ST_BCR_HOLD: begin
                ce_n     = 1'b0;
                cre      = 1'b1;
                mem_addr = BCR_VAL;
                cnt_d    = '0;
                state_d  = ST_BCR_WE;
            end
            ST_BCR_WE: begin
                ce_n     = 1'b0;
                we_n     = 1'b0;
                mem_addr = BCR_VAL;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BCR_WE_CYC - 1)) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                clk_en = 1'b1;
                if (bus.fml_stb) begin
                    addr_d = bus.fml_adr;
                    w_d    = '0;
                    if (bus.fml_we) begin
                        wdata_d = bus.fml_di;
                        wsel_d  = bus.fml_sel;
                        wr_ack  = 1'b1;
                        state_d = ST_WR_ADDR;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR, ST_WR_ADDR: begin
                clk_en   = 1'b1;
                ce_n     = 1'b0;
                adv_n    = 1'b0;
                we_n     = (state_q == ST_WR_ADDR) ? 1'b0 : 1'b1;
                mem_addr = addr_q;
                state_d  = (state_q == ST_WR_ADDR) ? ST_WR_XFER : ST_RD_XFER;
            end
            ST_RD_XFER, ST_WR_XFER: begin
                clk_en = 1'b1;
                ce_n   = 1'b0;
                if (state_q == ST_RD_XFER) begin
                    oe_n = 1'b0;
                end else begin
                    dq_oe = 1'b1;
                    dq_o  = w_q[0] ? wdata_q[31:16] : wdata_q[15:0];
                    be_n  = w_q[0] ? ~wsel_q[3:2] : ~wsel_q[1:0];
                end
                // A stalled word holds the index; a long enough stall aborts the burst.
                if (bus.mem_wait) begin
                    if (to_q == TO_W'(WAIT_TIMEOUT - 1)) begin
                        err_pulse = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end else begin
                    if (state_q == ST_RD_XFER) begin
                        if (!w_q[0]) begin
                            hold_d = bus.mem_dq_i;
                        end else begin
                            do_d     = {bus.mem_dq_i, hold_q};
                            rd_ack_d = 1'b1;
                        end
                    end else if (w_q[0] && (w_q != W_LAST)) begin
                        wdata_d = bus.fml_di;
                        wsel_d  = bus.fml_sel;
                        wr_ack  = 1'b1;
                    end
                    if (w_q == W_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        w_d = w_q + WIDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                clk_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase
    end

    assign bus.ready      = ready_q;
    assign bus.fml_do     = do_q;
    assign bus.fml_ack    = rd_ack_q | wr_ack;
    assign bus.err        = err_pulse;
    assign bus.mem_clk_en = clk_en;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_dq_o   = dq_o;
    assign bus.mem_dq_oe  = dq_oe;
    assign bus.mem_be_n   = be_n;
    assign bus.mem_we_n   = we_n;
    assign bus.mem_oe_n   = oe_n;
    assign bus.mem_ce_n   = ce_n;
    assign bus.mem_adv_n  = adv_n;
    assign bus.mem_cre    = cre;
endmodule

// File: tb/tb_psram_burst_ctrl.sv
// Self-checking bench: a behavioural PSRAM drives wait/read data and logs write
// words, while per-scenario tasks drive FML bursts against scoreboard queues.
module tb_psram_burst_ctrl;
    localparam int                ADDR_W       = 23;
    localparam int                BURST        = 4;
    localparam int                STARTUP_CYC  = 20;
    localparam logic [ADDR_W-1:0] BCR_VAL      = 23'h10_1D1F;
    localparam int                BCR_WE_CYC   = 6;
    localparam int                WAIT_TIMEOUT = 16;
    localparam int                INIT_CYC     = STARTUP_CYC + 2 + BCR_WE_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    psram_burst_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    psram_burst_ctrl #(
        .ADDR_W(ADDR_W), .BURST(BURST), .STARTUP_CYC(STARTUP_CYC),
        .BCR_VAL(BCR_VAL), .BCR_WE_CYC(BCR_WE_CYC), .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    logic [31:0] exp_rd [$];
    logic [17:0] exp_wr [$];
    logic [17:0] obs_wr [$];

    logic [15:0] rd_words [16];
    logic [31:0] wbeats [8];
    logic [3:0]  wsel [8];
    int          wait_cycles = 0;
    int          stall_word  = -1;
    int          lat  = 0;
    int          widx = 0;

    // Memory model: wait is high for the first wait_cycles transfer cycles (or
    // permanently from stall_word on); each wait-low cycle consumes one word.
    always @(negedge clk) begin
        if (rst || bus.mem_ce_n || !bus.mem_adv_n || (bus.mem_oe_n && !bus.mem_dq_oe)) begin
            lat          = 0;
            widx         = 0;
            bus.mem_wait = 1'b0;
            bus.mem_dq_i = 16'h0;
        end else begin
            bus.mem_wait = ((stall_word >= 0) && (widx >= stall_word)) || (lat < wait_cycles);
            bus.mem_dq_i = rd_words[widx % 16];
            if (!bus.mem_wait) begin
                if (bus.mem_dq_oe) obs_wr.push_back({bus.mem_be_n, bus.mem_dq_o});
                widx++;
            end
            lat++;
        end
    end

    task automatic do_reset_and_init(input string tag);
        int cyc = 0;
        int bcr_hits = 0;
        int we_lows = 0;
        int acks_seen = 0;
        bit bcr_ok = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        bus.fml_stb = 1'b0;
        @(posedge clk);
        #1;
        assertions++;
        if ({bus.ready, bus.fml_ack, bus.err, bus.mem_dq_oe, bus.mem_clk_en, bus.mem_ce_n,
             bus.mem_we_n, bus.mem_oe_n, bus.mem_adv_n, bus.mem_be_n, bus.mem_cre} !== 12'b0000_0111_1110) begin
            failures++;
            $display("[TB] FAIL %s_outputs: got %b expected %b", tag,
                     {bus.ready, bus.fml_ack, bus.err, bus.mem_dq_oe, bus.mem_clk_en, bus.mem_ce_n,
                      bus.mem_we_n, bus.mem_oe_n, bus.mem_adv_n, bus.mem_be_n, bus.mem_cre}, 12'b0000_0111_1110);
        end
        assertions++;
        if (bus.fml_do !== 32'h0) begin
            failures++;
            $display("[TB] FAIL %s_fml_do: got %h expected 00000000", tag, bus.fml_do);
        end
        @(negedge clk);
        rst = 1'b0;
        while (bus.ready !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!bus.mem_adv_n && bus.mem_cre) begin
                bcr_hits++;
                if (bus.mem_addr !== BCR_VAL) bcr_ok = 1'b0;
            end
            if (bus.mem_we_n === 1'b0) we_lows++;
            if (bus.fml_ack === 1'b1) acks_seen++;
        end
        assertions++;
        if (cyc != INIT_CYC) begin
            failures++;
            $display("[TB] FAIL %s_ready_latency: got %0d cycles expected %0d", tag, cyc, INIT_CYC);
        end
        assertions++;
        if (bcr_hits != 1 || !bcr_ok) begin
            failures++;
            $display("[TB] FAIL %s_bcr_addr: got %0d adv cycles (addr ok=%0d) expected 1 with %h", tag, bcr_hits, bcr_ok, BCR_VAL);
        end
        assertions++;
        if (we_lows != BCR_WE_CYC) begin
            failures++;
            $display("[TB] FAIL %s_bcr_we: got %0d we_n low cycles expected %0d", tag, we_lows, BCR_WE_CYC);
        end
        assertions++;
        if (acks_seen != 0) begin
            failures++;
            $display("[TB] FAIL %s_init_acks: got %0d expected 0", tag, acks_seen);
        end
    endtask

    // Drives one FML burst from the IDLE cycle to the DONE cycle; read beats are
    // popped from exp_rd and compared as each ack appears.
    task automatic run_burst(input bit we, input logic [ADDR_W-1:0] adr,
                             output int acks, output int errs, output bit ce_ok,
                             output logic [ADDR_W-1:0] seen_adr, output bit done);
        int b = 0;
        bit err_prev = 1'b0;
        bit seen_low = 1'b0;
        logic [31:0] e;
        acks = 0; errs = 0; ce_ok = 1'b0; seen_adr = '0; done = 1'b0;
        @(negedge clk);
        bus.fml_stb = 1'b1;
        bus.fml_we  = we;
        bus.fml_adr = adr;
        bus.fml_di  = wbeats[0];
        bus.fml_sel = wsel[0];
        for (int c = 0; c < 150 && !done; c++) begin
            #2;
            if (err_prev) ce_ok = (bus.mem_ce_n === 1'b1);
            err_prev = (bus.err === 1'b1);
            if (err_prev) errs++;
            if (!bus.mem_adv_n && !bus.mem_ce_n) seen_adr = bus.mem_addr;
            if (bus.fml_ack === 1'b1) begin
                acks++;
                if (!we) begin
                    assertions++;
                    if (exp_rd.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL rd_beat: got %h with empty scoreboard", bus.fml_do);
                    end else begin
                        e = exp_rd.pop_front();
                        if (bus.fml_do !== e) begin
                            failures++;
                            $display("[TB] FAIL rd_beat: got %h expected %h", bus.fml_do, e);
                        end
                    end
                end else if (b < BURST - 1) begin
                    b++;
                end
            end
            if (bus.mem_ce_n === 1'b0) seen_low = 1'b1;
            else if (seen_low) done = 1'b1;
            if (!done) begin
                @(negedge clk);
                bus.fml_stb = 1'b0;
                bus.fml_di  = wbeats[b];
                bus.fml_sel = wsel[b];
            end
        end
    endtask

    task automatic check_read_burst(input string tag, input logic [ADDR_W-1:0] adr);
        int acks, errs;
        bit ce_ok, done;
        logic [ADDR_W-1:0] seen_adr;
        for (int b = 0; b < BURST; b++) exp_rd.push_back({rd_words[2*b+1], rd_words[2*b]});
        run_burst(1'b0, adr, acks, errs, ce_ok, seen_adr, done);
        assertions++;
        if (!done || acks != BURST || errs != 0 || exp_rd.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_acks: got done=%0d acks=%0d errs=%0d left=%0d expected 1/%0d/0/0",
                     tag, done, acks, errs, exp_rd.size(), BURST);
        end
        assertions++;
        if (seen_adr !== adr) begin
            failures++;
            $display("[TB] FAIL %s_addr: got %h expected %h", tag, seen_adr, adr);
        end
        exp_rd.delete();
    endtask

    task automatic test_reset();
        do_reset_and_init("reset");
    endtask

    task automatic test_read();
        for (int i = 0; i < 16; i++) rd_words[i] = 16'h1111 * 16'(i % 8 + 1);
        wait_cycles = 3;
        check_read_burst("read", 23'h000100);
    endtask

    task automatic test_write();
        int acks, errs;
        bit ce_ok, done;
        logic [ADDR_W-1:0] seen_adr;
        logic [17:0] o, e;
        wbeats[0] = 32'hA1B2_C3D4; wsel[0] = 4'b1111;
        wbeats[1] = 32'h5566_7788; wsel[1] = 4'b0110;
        wbeats[2] = 32'hDEAD_BEEF; wsel[2] = 4'b1100;
        wbeats[3] = 32'h0F1E_2D3C; wsel[3] = 4'b0011;
        obs_wr.delete();
        exp_wr.delete();
        for (int k = 0; k < BURST; k++) begin
            exp_wr.push_back({~wsel[k][1:0], wbeats[k][15:0]});
            exp_wr.push_back({~wsel[k][3:2], wbeats[k][31:16]});
        end
        wait_cycles = 1;
        run_burst(1'b1, 23'h0002A0, acks, errs, ce_ok, seen_adr, done);
        assertions++;
        if (!done || acks != BURST || errs != 0) begin
            failures++;
            $display("[TB] FAIL write_acks: got done=%0d acks=%0d errs=%0d expected 1/%0d/0", done, acks, errs, BURST);
        end
        assertions++;
        if (obs_wr.size() != 2 * BURST) begin
            failures++;
            $display("[TB] FAIL write_words: got %0d words expected %0d", obs_wr.size(), 2 * BURST);
        end else begin
            assertions++;
            if (obs_wr[2][17:16] !== 2'b01 || obs_wr[3][17:16] !== 2'b10) begin
                failures++;
                $display("[TB] FAIL write_be_beat1: got %b/%b expected 01/10", obs_wr[2][17:16], obs_wr[3][17:16]);
            end
        end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            assertions++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL write_word: got be_n/dq %h expected %h", o, e);
            end
        end
        obs_wr.delete();
        exp_wr.delete();
    endtask

    task automatic test_timeout();
        int acks, errs;
        bit ce_ok, done;
        logic [ADDR_W-1:0] seen_adr;
        for (int i = 0; i < 16; i++) rd_words[i] = 16'hC000 + 16'(i);
        for (int b = 0; b < BURST; b++) exp_rd.push_back({rd_words[2*b+1], rd_words[2*b]});
        wait_cycles = 0;
        stall_word  = 3;
        run_burst(1'b0, 23'h000400, acks, errs, ce_ok, seen_adr, done);
        assertions++;
        if (!done || errs != 1 || !ce_ok) begin
            failures++;
            $display("[TB] FAIL timeout_err: got done=%0d errs=%0d ce_n_after=%0d expected 1/1/1", done, errs, ce_ok);
        end
        assertions++;
        if (acks != 1 || exp_rd.size() != BURST - 1) begin
            failures++;
            $display("[TB] FAIL timeout_acks: got %0d acks expected 1", acks);
        end
        exp_rd.delete();
        stall_word = -1;
        for (int i = 0; i < 16; i++) rd_words[i] = 16'h0F00 ^ 16'(i * 16'h0101);
        check_read_burst("after_timeout", 23'h000500);
    endtask

    task automatic test_back_to_back();
        wait_cycles = 0;
        test_write();
        for (int i = 0; i < 16; i++) rd_words[i] = 16'h7A00 + 16'(i * 3);
        check_read_burst("back_to_back", 23'h7FFFF8);
    endtask

    task automatic test_reset_mid_write();
        int guard = 0;
        wait_cycles = 2;
        @(negedge clk);
        bus.fml_stb = 1'b1;
        bus.fml_we  = 1'b1;
        bus.fml_adr = 23'h000800;
        bus.fml_di  = 32'h1234_5678;
        bus.fml_sel = 4'b1111;
        @(negedge clk);
        bus.fml_stb = 1'b0;
        while (bus.mem_dq_oe !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        assertions++;
        if (guard >= 20) begin
            failures++;
            $display("[TB] FAIL mid_write_start: got no write transfer within %0d cycles", guard);
        end
        repeat (3) @(negedge clk);
        do_reset_and_init("mid_write_reset");
        obs_wr.delete();
    endtask

    initial begin
        bus.fml_adr  = '0;
        bus.fml_stb  = 1'b0;
        bus.fml_we   = 1'b0;
        bus.fml_sel  = 4'h0;
        bus.fml_di   = 32'h0;
        bus.mem_dq_i = 16'h0;
        bus.mem_wait = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wbeats[i] = 32'h0;
            wsel[i]   = 4'hF;
        end
        for (int i = 0; i < 16; i++) rd_words[i] = 16'h0;
        $display("[TB] starting psram_burst_ctrl bench");
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        test_read();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/psram_burst_ctrl.md
PSRAM_BURST_CTRL -- requirements
Module: psram_burst_ctrl

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
  ADDR_W, 23, PSRAM word-address width.
  BURST, 4, FML beats per transaction, legal values 1, 2, 4, 8; each beat is 32 bits, i.e. two 16-bit memory words.
  STARTUP_CYC, 15000, power-up wait in clk cycles before BCR write.
  BCR_VAL, 23'h10_1D1F, value driven on mem_addr during BCR write.
  BCR_WE_CYC, 6, mem_we_n low cycles for BCR write.
  WAIT_TIMEOUT, 64, max consecutive mem_wait-high cycles before abort.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  system clock; the block uses one clock.
  rst  in  1  reset, synchronous and active-high.
  ready  out  1  initialisation complete.
  fml_adr  in  ADDR_W  burst start word address.
  fml_stb  in  1  request.
  fml_we  in  1  1 = write.
  fml_sel  in  4  byte enables of current write beat, active-high.
  fml_di  in  32  write data of current beat.
  fml_do  out  32  read data.
  fml_ack  out  1  per-beat strobe.
  err  out  1  one-cycle timeout abort pulse.
  mem_clk_en  out  1  PSRAM clock gate.
  mem_addr  out  ADDR_W  PSRAM address.
  mem_dq_i  in  16  PSRAM read data.
  mem_dq_o  out  16  PSRAM write data.
  mem_dq_oe  out  1  data bus drive enable.
  mem_be_n  out  2  byte enables, active-low.
  mem_we_n, mem_oe_n, mem_ce_n, mem_adv_n  out  1 each  strobes, active-low.
  mem_cre  out  1  config register enable.
  mem_wait  in  1  high = memory not ready.

Function
REQ-003 SHALL implement states STARTUP, BCR_ADV, BCR_HOLD, BCR_WE, IDLE, RD_ADDR, RD_XFER, WR_ADDR, WR_XFER, DONE.
REQ-004 STARTUP: count STARTUP_CYC cycles -> BCR_ADV. BCR_ADV: ce_n=0, adv_n=0, cre=1, mem_addr=BCR_VAL. BCR_HOLD: ce_n=0, cre=1. BCR_WE: ce_n=0, we_n=0 for BCR_WE_CYC cycles -> IDLE.
REQ-005 ready SHALL be 0 until IDLE is first entered, then remain 1 until reset.
REQ-006 IDLE SHALL hold mem_clk_en=1 and all strobes inactive. With fml_stb=1, it latches fml_adr and goes to WR_ADDR if fml_we=1, else RD_ADDR.
REQ-007 A write accept SHALL also latch fml_di/fml_sel as beat 0 and pulse fml_ack in the accept cycle.
REQ-008 RD_ADDR/WR_ADDR SHALL last one cycle: ce_n=0, adv_n=0, we_n=0 for writes, mem_addr=latched address.
REQ-009 In the XFER states ce_n=0; for reads oe_n=0; for writes dq_oe=1. A word transfers in each cycle with mem_wait=0; with mem_wait=1 the word index holds.
REQ-010 Word index w runs 0..2*BURST-1; even w = low half of beat w/2, odd w = high half.
REQ-011 Read: even word captured into a holding register. Odd word sets fml_do={mem_dq_i, held} on the next edge with fml_ack=1 for that one cycle. Exactly BURST acks per read.
REQ-012 Write: even word drives data[15:0], be_n=~sel[1:0]; odd word drives data[31:16], be_n=~sel[3:2].
REQ-013 On the odd word of beat k<BURST-1, the block latches fml_di/fml_sel as beat k+1 and pulses fml_ack. Exactly BURST acks per write.
REQ-014 After the last word transfers: -> DONE (ce_n=1, one cycle) -> IDLE. fml_stb is not sampled in DONE.
REQ-015 fml_stb deassertion mid-transaction SHALL be ignored; the burst completes.
REQ-016 A timeout counter SHALL clear on any cycle with mem_wait=0 and increment while mem_wait=1 in XFER.
REQ-017 When the counter reaches WAIT_TIMEOUT: err=1 for one cycle, no further fml_ack, -> DONE.
REQ-018 Addresses do not wrap in the controller; the PSRAM's burst mode governs wrap.

Reset
REQ-019 rst=1 at a clock edge SHALL force STARTUP and clear all counters, including mid-transaction; no further acks follow.
REQ-020 Reset values: ready=0, fml_ack=0, err=0, fml_do=0, dq_oe=0, mem_clk_en=0, ce_n=we_n=oe_n=adv_n=1, be_n=2'b11, cre=0.

Verification
REQ-021 Reset release, no requests -> ready rises STARTUP_CYC+2+BCR_WE_CYC cycles later; mem_addr=BCR_VAL with cre=1 during BCR_ADV.
REQ-022 Read BURST=4 at 0x100, wait low after 3 cycles, words 0x1111..0x8888 -> fml_do 0x22221111, 0x44443333, 0x66665555, 0x88887777, each with one fml_ack.
REQ-023 Write BURST=4, sel 4'b0110 on beat 1 -> mem_be_n 2'b01 then 2'b10 for beat 1; fml_di value of each ack cycle appears on mem_dq_o.
REQ-024 mem_wait held high WAIT_TIMEOUT cycles mid-read -> single err pulse, ce_n=1 next cycle, ack count below BURST, next request serviced normally.
REQ-025 rst asserted in the middle of a write burst -> outputs at reset values after the edge, then full STARTUP/BCR sequence.
